// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM read/write responders: burst codes,
// response codes and the read-side FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    SEND  = 2'b10
  } rd_state_t;

endpackage

// File: rtl/axi_sram_read_resp_if.sv
// AR and R channel bundle between an interconnect slave port and the
// SRAM read responder.
interface axi_sram_read_resp_if #(
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32
);
  logic [IDS_W-1:0]  ARID_S;
  logic [31:0]       ARADDR_S;
  logic [3:0]        ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic              ARVALID_S;
  logic              ARREADY_S;

  logic [IDS_W-1:0]  RID_S;
  logic [DATA_W-1:0] RDATA_S;
  logic [1:0]        RRESP_S;
  logic              RLAST_S;
  logic              RVALID_S;
  logic              RREADY_S;

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-word-address generator for AXI FIXED/INCR/WRAP bursts;
// shared by the read and write SRAM responders.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0] cur_addr,
  input  logic [3:0]    len,
  input  burst_t        burst,
  output logic [AW-1:0] next_addr,
  output logic          wrap_illegal
);

  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_addr;
  logic [AW-1:0] mask;
  logic          len_is_wrap;

  assign incr_addr    = cur_addr + AW'(1);
  assign mask         = AW'(len);
  assign len_is_wrap  = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  assign wrap_illegal = (burst == WRAP) && !len_is_wrap;

  // Bits under the wrap mask count up, bits above it stay pinned to the window.
  for (genvar gi = 0; gi < AW; gi++) begin : g_wrap
    assign wrap_addr[gi] = mask[gi] ? incr_addr[gi] : cur_addr[gi];
  end

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      FIXED:   next_addr = cur_addr;
      WRAP:    next_addr = len_is_wrap ? wrap_addr : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_read_resp.sv
// AXI4 slave read responder over a 1-cycle-latency single-port SRAM.
// Define RD_DECERR_EN to answer out-of-window addresses with DECERR.
module axi_sram_read_resp
  import axi_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          IDS_W    = 8,
  parameter int          MEM_AW   = 14,
  parameter logic [31:0] BASE_TAG = 32'h0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_sram_read_resp_if.slave  s,
  output logic                 mem_cs,
  output logic                 mem_oe,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata
);

  rd_state_t         state_reg;
  logic [IDS_W-1:0]  id_reg;
  logic [MEM_AW-1:0] cur_addr_reg;
  logic [3:0]        len_reg;
  logic [3:0]        beat_cnt_reg;
  burst_t            burst_reg;
  logic              decerr_reg;

  logic              arready_reg;
  logic              rvalid_reg;
  logic              rlast_reg;
  logic [1:0]        rresp_reg;
  logic [IDS_W-1:0]  rid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              mem_cs_reg;
  logic              mem_oe_reg;
  logic [MEM_AW-1:0] mem_addr_reg;

  logic [MEM_AW-1:0] next_addr;
  logic              wrap_illegal;
  logic [MEM_AW-1:0] ar_word_addr;
  logic              ar_decerr;
  logic              unused_bits;

  assign ar_word_addr = s.ARADDR_S[MEM_AW+1:2];

`ifdef RD_DECERR_EN
  assign ar_decerr   = (s.ARADDR_S[31:MEM_AW+2] != BASE_TAG[29-MEM_AW:0]);
  assign unused_bits = ^{s.ARSIZE_S, s.ARADDR_S[1:0]};
`else
  assign ar_decerr   = 1'b0;
  assign unused_bits = ^{s.ARSIZE_S, s.ARADDR_S[1:0], s.ARADDR_S[31:MEM_AW+2], BASE_TAG};
`endif

  axi_burst_addr_gen #(.AW(MEM_AW)) u_addr_gen (
    .cur_addr     (cur_addr_reg),
    .len          (len_reg),
    .burst        (burst_reg),
    .next_addr    (next_addr),
    .wrap_illegal (wrap_illegal)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      id_reg       <= '0;
      cur_addr_reg <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      burst_reg    <= FIXED;
      decerr_reg   <= 1'b0;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rlast_reg    <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rid_reg      <= '0;
      rdata_reg    <= '0;
      mem_cs_reg   <= 1'b0;
      mem_oe_reg   <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rvalid_reg <= 1'b0;
          rlast_reg  <= 1'b0;
          if (s.ARVALID_S && arready_reg) begin
            id_reg       <= s.ARID_S;
            cur_addr_reg <= ar_word_addr;
            len_reg      <= s.ARLEN_S;
            burst_reg    <= burst_t'(s.ARBURST_S);
            beat_cnt_reg <= '0;
            decerr_reg   <= ar_decerr;
            arready_reg  <= 1'b0;
            // Decode-error bursts keep the SRAM idle but still spend the FETCH cycle.
            mem_cs_reg   <= !ar_decerr;
            mem_oe_reg   <= !ar_decerr;
            mem_addr_reg <= ar_word_addr;
            state_reg    <= FETCH;
          end else begin
            arready_reg <= 1'b1;
          end
        end

        FETCH: begin
          mem_cs_reg <= 1'b0;
          mem_oe_reg <= 1'b0;
          rid_reg    <= id_reg;
          rdata_reg  <= decerr_reg ? '0 : mem_rdata;
          if (decerr_reg)
            rresp_reg <= RESP_DECERR;
          else if (burst_reg == RSVD || wrap_illegal)
            rresp_reg <= RESP_SLVERR;
          else
            rresp_reg <= RESP_OKAY;
          rvalid_reg <= 1'b1;
          rlast_reg  <= (beat_cnt_reg == len_reg);
          state_reg  <= SEND;
        end

        SEND: begin
          if (s.RREADY_S) begin
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
            if (rlast_reg) begin
              arready_reg <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 4'd1;
              cur_addr_reg <= next_addr;
              mem_cs_reg   <= !decerr_reg;
              mem_oe_reg   <= !decerr_reg;
              mem_addr_reg <= next_addr;
              state_reg    <= FETCH;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s.ARREADY_S = arready_reg;
  assign s.RVALID_S  = rvalid_reg;
  assign s.RLAST_S   = rlast_reg;
  assign s.RRESP_S   = rresp_reg;
  assign s.RID_S     = rid_reg;
  assign s.RDATA_S   = rdata_reg;
  assign mem_cs      = mem_cs_reg;
  assign mem_oe      = mem_oe_reg;
  assign mem_addr    = mem_addr_reg;

endmodule
